// File: rtl/burst_address_register.sv
// Memory address register with single-address load, same-cycle bypass
// and an auto-incrementing burst mode driven by a per-beat acknowledge.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | holds address; loads on wr_en/burst_start, bar_in bypassed
// ST_BURST | presents current beat address, advances on each beat_ack
module burst_address_register #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int BEAT_BYTES = 4
) (
  input  logic                  bar_clk,
  input  logic                  bar_rst,
  input  logic [ADDR_WIDTH-1:0] bar_in,
  input  logic                  bar_wr_en,
  input  logic                  bar_burst_start,
  input  logic [LEN_WIDTH-1:0]  bar_burst_len,
  input  logic                  bar_beat_ack,
  input  logic                  bar_abort,
  output logic [ADDR_WIDTH-1:0] bar_out,
  output logic                  bar_busy,
  output logic                  bar_last,
  output logic                  bar_done,
  output logic                  bar_misaligned
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] BEAT_INC = ADDR_WIDTH'(BEAT_BYTES);
  localparam logic [LEN_WIDTH-1:0]  REM_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  REM_ZERO = '0;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  done_q, done_d;
  logic                  rem_is_zero;

  assign rem_is_zero = (rem_q == REM_ZERO);

  // Next-state decision: loads in IDLE, beat advance / completion / abort in BURST.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bar_burst_start) begin
          addr_d  = bar_in;
          rem_d   = bar_burst_len;
          state_d = ST_BURST;
        end else if (bar_wr_en) begin
          addr_d = bar_in;
        end
      end
      ST_BURST: begin
        if (bar_beat_ack) begin
          // The acked beat is always consumed, even when abort arrives with it,
          // so the register ends up on the next un-issued address.
          addr_d = addr_q + BEAT_INC;
          if (rem_is_zero) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - REM_ONE;
            if (bar_abort) begin
              state_d = ST_IDLE;
            end
          end
        end else if (bar_abort) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any burst in flight without a done pulse.
  always_ff @(posedge bar_clk or posedge bar_rst) begin
    if (bar_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // In IDLE a load strobe forwards bar_in so memory sees the address this cycle.
  assign bar_out  = ((state_q == ST_IDLE) && (bar_wr_en || bar_burst_start)) ? bar_in : addr_q;
  assign bar_busy = (state_q == ST_BURST);
  assign bar_last = (state_q == ST_BURST) && rem_is_zero;
  assign bar_done = done_q;

  generate
    if (BEAT_BYTES > 1) begin : g_align
      localparam int ALIGN_BITS = $clog2(BEAT_BYTES);
      assign bar_misaligned = |bar_out[ALIGN_BITS-1:0];
    end else begin : g_no_align
      assign bar_misaligned = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_burst_address_register.sv
// Bench for burst_address_register: directed vector table, hand-written
// reset sequences and random traffic against a queue-based model.
module tb_burst_address_register;

  localparam int BEAT = 4;

  logic        clk, rst;
  logic        wr, start, ack, abort;
  logic [3:0]  len;
  logic [31:0] din;
  logic [31:0] out;
  logic        busy, last, done, mis;

  int n_cmp = 0;
  int n_bad = 0;

  burst_address_register #(.ADDR_WIDTH(32), .LEN_WIDTH(4), .BEAT_BYTES(4)) dut (
    .bar_clk(clk), .bar_rst(rst), .bar_in(din), .bar_wr_en(wr),
    .bar_burst_start(start), .bar_burst_len(len), .bar_beat_ack(ack),
    .bar_abort(abort), .bar_out(out), .bar_busy(busy), .bar_last(last),
    .bar_done(done), .bar_misaligned(mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a burst is the list of beat addresses still to be acked.
  logic [31:0] q[$];
  logic [31:0] m_addr;
  logic        m_done;

  function automatic void model_reset();
    q.delete();
    m_addr = '0;
    m_done = 1'b0;
  endfunction

  function automatic logic [35:0] model_exp();
    logic [31:0] o;
    logic        b;
    b = (q.size() != 0);
    if (b) o = q[0];
    else if (wr || start) o = din;
    else o = m_addr;
    return {o, b, (q.size() == 1), m_done, ((o % BEAT) != 0)};
  endfunction

  function automatic void model_step();
    logic nd;
    nd = 1'b0;
    if (q.size() != 0) begin
      if (ack) begin
        m_addr = q.pop_front() + 32'(BEAT);
        if (q.size() == 0) nd = 1'b1;
        else if (abort) q.delete();
      end else if (abort) begin
        m_addr = q[0];
        q.delete();
      end
    end else if (start) begin
      m_addr = din;
      for (int i = 0; i <= int'(len); i++) q.push_back(din + 32'(i * BEAT));
    end else if (wr) begin
      m_addr = din;
    end
    m_done = nd;
  endfunction

  function automatic logic [35:0] got();
    return {out, busy, last, done, mis};
  endfunction

  task automatic check(input string name, input logic [35:0] g, input logic [35:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got out=%h busy/last/done/mis=%b required out=%h busy/last/done/mis=%b",
               name, g[35:4], g[3:0], e[35:4], e[3:0]);
    end
  endtask

  task automatic finish_cycle(input string name);
    check({name, "/model"}, got(), model_exp());
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic step(input logic w, input logic s, input logic [3:0] ln, input logic a,
                      input logic ab, input logic [31:0] d, input string name);
    wr = w; start = s; len = ln; ack = a; abort = ab; din = d;
    #1;
    finish_cycle(name);
  endtask

  task automatic mid_reset(input string name);
    wr = 0; start = 0; len = 0; ack = 0; abort = 0; din = 32'h0;
    #2 rst = 1'b1;
    #1 check(name, got(), 36'h0);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr, start;
    logic [3:0]  len;
    logic        ack, abort;
    logic [31:0] din;
    logic [31:0] e_out;
    logic        e_busy, e_last, e_done, e_mis;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic w, input logic s, input logic [3:0] ln, input logic a,
                     input logic ab, input logic [31:0] d, input logic [31:0] eo,
                     input logic eb, input logic el, input logic ed, input logic em);
    vec_t v;
    v.wr = w; v.start = s; v.len = ln; v.ack = a; v.abort = ab; v.din = d;
    v.e_out = eo; v.e_busy = eb; v.e_last = el; v.e_done = ed; v.e_mis = em;
    tbl.push_back(v);
  endtask

  initial begin
    //  wr st len ack ab din           out           b  l  d  m
    add(1, 0, 0, 0, 0, 32'h1000,     32'h1000,     0, 0, 0, 0); // load with bypass
    add(0, 0, 0, 0, 0, 32'hDEAD0000, 32'h1000,     0, 0, 0, 0); // held
    add(0, 1, 3, 0, 0, 32'h2000,     32'h2000,     0, 0, 0, 0); // 4-beat start
    add(0, 0, 0, 1, 0, 32'h0,        32'h2000,     1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h0,        32'h2004,     1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h0,        32'h2008,     1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h0,        32'h200C,     1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h2010,     0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h2010,     0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 32'h40,       32'h40,       0, 0, 0, 0); // stalled acks
    add(1, 0, 0, 0, 0, 32'h999,      32'h40,       1, 0, 0, 0); // wr ignored in burst
    add(0, 0, 0, 0, 0, 32'h0,        32'h40,       1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h0,        32'h40,       1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h44,       1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h44,       1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 32'h0,        32'h44,       1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h48,       0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h48,       0, 0, 0, 0);
    add(0, 1, 7, 0, 0, 32'h100,      32'h100,      0, 0, 0, 0); // abort without ack
    add(0, 0, 0, 1, 0, 32'h0,        32'h100,      1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h0,        32'h104,      1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h0,        32'h108,      1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h108,      0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 32'h200,      32'h200,      0, 0, 0, 0); // abort+ack on last
    add(0, 0, 0, 1, 1, 32'h0,        32'h200,      1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h204,      0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 0, 0); // wrap
    add(0, 0, 0, 1, 0, 32'h0,        32'hFFFFFFFC, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h4,        0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 32'h1002,     32'h1002,     0, 0, 0, 1); // misaligned
    add(0, 0, 0, 1, 0, 32'h0,        32'h1002,     1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 32'h0,        32'h1006,     1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 32'h0,        32'h100A,     0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 32'h10,       32'h10,       0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 32'h300,      32'h300,      0, 0, 0, 0); // back-to-back
    add(0, 0, 0, 1, 0, 32'h0,        32'h300,      1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 32'h304,      32'h304,      0, 0, 1, 0); // start during done
    add(0, 0, 0, 1, 0, 32'h0,        32'h304,      1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h308,      0, 0, 1, 0);

    rst = 1'b1; wr = 0; start = 0; len = 0; ack = 0; abort = 0; din = 32'h0;
    model_reset();
    #3 check("reset_state", got(), 36'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      wr = tbl[i].wr; start = tbl[i].start; len = tbl[i].len;
      ack = tbl[i].ack; abort = tbl[i].abort; din = tbl[i].din;
      #1;
      check($sformatf("vec%0d", i), got(),
            {tbl[i].e_out, tbl[i].e_busy, tbl[i].e_last, tbl[i].e_done, tbl[i].e_mis});
      finish_cycle($sformatf("vec%0d", i));
    end

    // Reset at beat 2 of a 4-beat burst, then a fresh burst.
    step(0, 1, 3, 0, 0, 32'h2000, "rb_start");
    step(0, 0, 0, 1, 0, 32'h0, "rb_beat1");
    mid_reset("rst_mid_burst");
    step(0, 1, 2, 0, 0, 32'h500, "post_rst_start");
    step(0, 0, 0, 1, 0, 32'h0, "post_rst_b0");
    step(0, 0, 0, 1, 0, 32'h0, "post_rst_b1");
    step(0, 0, 0, 1, 0, 32'h0, "post_rst_b2");
    #1 check("post_rst_done", got(), {32'h50C, 4'b0010});

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(3) != 0) d[1:0] = 2'b00;
      if ($urandom_range(299) == 0) mid_reset("rnd_rst");
      else
        step($urandom_range(7) == 0, $urandom_range(5) == 0, 4'($urandom_range(15)),
             $urandom_range(1) == 1, $urandom_range(15) == 0, d, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_address_register.md
Name: burst_address_register

Overview:
Parametrised successor to the single-word memory address register. It holds a memory address and supports single-address loads with same-cycle bypass. It adds a burst mode that auto-increments the address by a fixed beat size over a programmable beat count, under a per-beat acknowledge handshake. It sits between the control unit and the data-memory / instruction-fetch port, driving the memory address bus.

Parameters:
ADDR_WIDTH, 32, width of address in/out and internal register.
LEN_WIDTH, 4, width of burst length field; max burst = 2^LEN_WIDTH beats.
BEAT_BYTES, 4, address increment per beat; power of two, >= 1.

Ports:
bar_clk  input  1  clock; all state updates on rising edge.
bar_rst  input  1  reset, asynchronous, active-high; clears all state immediately.
bar_in  input  ADDR_WIDTH  address to load / burst base address.
bar_wr_en  input  1  single-address load strobe, honoured in IDLE only.
bar_burst_start  input  1  start burst from bar_in, honoured in IDLE only.
bar_burst_len  input  LEN_WIDTH  number of beats minus 1, sampled with bar_burst_start.
bar_beat_ack  input  1  memory accepted current beat address, honoured in BURST only.
bar_abort  input  1  terminate burst, honoured in BURST only.
bar_out  output  ADDR_WIDTH  address presented to memory.
bar_busy  output  1  high while in BURST.
bar_last  output  1  high in BURST when the current beat is the final one.
bar_done  output  1  one-cycle registered pulse after the final beat is acked.
bar_misaligned  output  1  bar_out low log2(BEAT_BYTES) bits non-zero; constant 0 when BEAT_BYTES=1.

Behaviour:
- Reset: addr register=0, remaining=0, state=IDLE, done=0. Outputs: bar_out=0 (absent strobes), busy=0, last=0, done=0, misaligned=0. Reset asserted mid-burst aborts immediately, with no done pulse.
- States: IDLE, BURST. Each decision below is taken at the rising edge.
- IDLE, bar_burst_start=1: reg<=bar_in, remaining<=bar_burst_len, state<=BURST. Takes priority over bar_wr_en; both load bar_in.
- IDLE, bar_wr_en=1 only: reg<=bar_in, state stays IDLE.
- IDLE, no strobe: reg holds.
- IDLE bypass (combinational): bar_out=bar_in while bar_wr_en or bar_burst_start is high; otherwise bar_out=reg. Zero-latency address.
- BURST: bar_out=reg (no bypass); busy=1; last=(remaining==0). bar_wr_en and bar_burst_start are ignored.
- BURST, bar_beat_ack=1, remaining!=0: reg<=reg+BEAT_BYTES, remaining<=remaining-1.
- BURST, bar_beat_ack=1, remaining==0: reg<=reg+BEAT_BYTES, state<=IDLE, done<=1 for exactly the next cycle. After the burst, reg holds the address following the last beat, so back-to-back bursts are contiguous.
- BURST, no ack: reg, remaining and state hold; bar_out is stable until acked.
- BURST, bar_abort=1 without ack: state<=IDLE, reg holds the un-acked beat address, no done.
- BURST, bar_abort=1 with ack: the ack is applied first (increment, decrement), then state<=IDLE. done pulses only if that beat was the last.
- Arithmetic: the increment is modulo 2^ADDR_WIDTH. Wrap from max to 0 is silent, with no flag. remaining never underflows.
- bar_burst_len=0 is a single-beat burst: last=1 on the first BURST cycle.
- Minimum turnaround: a new burst_start is accepted in the cycle done is high, because state is already IDLE.
- bar_misaligned is combinational on bar_out and is valid in all states, including during bypass. It is informational only and does not block the burst.

Test Plan:
- Reset/load: assert bar_rst mid-cycle -> bar_out=0, busy=0 immediately. bar_wr_en=1, bar_in=0x1000 -> bar_out=0x1000 same cycle, held 0x1000 after strobe drops.
- 4-beat burst: start bar_in=0x2000, len=3, ack every cycle -> bar_out 0x2000, 0x2004, 0x2008, 0x200C; last high on 0x200C only; done pulses one cycle; bar_out=0x2010 after.
- Stalled ack: len=1 base 0x40, ack only every 3rd cycle -> bar_out holds each beat until ack; completes after 2 acks, done once.
- Abort: base 0x100, len=7, ack 2 beats then abort without ack -> IDLE, bar_out=0x108, no done. Repeat with abort+ack on the last beat -> done pulses.
- Wrap/misalign: base 0xFFFFFFFC, len=1 -> bar_out 0xFFFFFFFC then 0x00000000. Base 0x1002 -> misaligned=1 on every beat. wr_en during BURST has no effect.
- Reset mid-burst: bar_rst asserted at beat 2 of 4 -> busy, last, done=0 and bar_out=0 asynchronously; next burst_start works normally.
